// File: rtl/instr_fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: opcode constants,
// instruction word layout and FSM state encoding.
package instr_fetch_sequencer_pkg;

   localparam logic [3:0] OpAdd   = 4'b0000;
   localparam logic [3:0] OpSub   = 4'b0001;
   localparam logic [3:0] OpStore = 4'b0010;
   localparam logic [3:0] OpLoad  = 4'b0011;
   localparam logic [3:0] OpAnd   = 4'b0101;
   localparam logic [3:0] OpOr    = 4'b0110;
   localparam logic [3:0] OpXor   = 4'b0111;
   localparam logic [3:0] OpNot   = 4'b1000;
   localparam logic [3:0] OpShl   = 4'b1001;
   localparam logic [3:0] OpShr   = 4'b1010;
   localparam logic [3:0] OpHalt  = 4'b1111;

   typedef struct packed {
      logic [3:0] opcode;
      logic [3:0] addr;
      logic [3:0] data;
   } instr_t;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StFetch = 3'd1,
      StIssue = 3'd2,
      StGap   = 3'd3,
      StDone  = 3'd4
   } state_e;

   // Only STORE instructions write CPU storage.
   function automatic logic is_store(logic [3:0] opcode);
      return opcode == OpStore;
   endfunction

endpackage

// File: rtl/instr_fetch_sequencer_prog_mem.sv
// 16x12-bit program register file: synchronous write, combinational read.
// Contents are deliberately not reset.
module prog_mem_16x12 (
   input  logic        clk,
   input  logic        we,
   input  logic [3:0]  waddr,
   input  logic [11:0] wdata,
   input  logic [3:0]  raddr,
   output logic [11:0] rdata
);

   logic [11:0] mem_q [16];

   // Registered write port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: steps through the program memory from entry 0,
// presenting each instruction on the CPU bus for HOLD_CYCLES cycles separated
// by a one-cycle gap, until a HALT opcode, entry 15, or an abort.
module instr_fetch_sequencer
   import instr_fetch_sequencer_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 3,
   parameter logic [3:0]  HALT_OP     = 4'b1111
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ena,
   input  logic        prog_we,
   input  logic [3:0]  prog_waddr,
   input  logic [11:0] prog_wdata,
   input  logic        start,
   input  logic        abort,
   output logic [3:0]  cpu_opcode,
   output logic [3:0]  cpu_addr,
   output logic [3:0]  cpu_data,
   output logic        cpu_we,
   output logic        busy,
   output logic        done,
   output logic [3:0]  pc
);

   localparam logic [2:0] HoldLast = 3'(HOLD_CYCLES - 1);

   state_e      state_q, state_d;
   logic [3:0]  pc_q, pc_d;
   logic [2:0]  hold_q, hold_d;
   instr_t      instr_q, instr_d;
   logic [3:0]  cpu_opcode_q, cpu_opcode_d;
   logic [3:0]  cpu_addr_q, cpu_addr_d;
   logic [3:0]  cpu_data_q, cpu_data_d;
   logic        cpu_we_q, cpu_we_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        mem_we;
   logic [11:0] mem_rdata;
   logic        running;

   assign running = (state_q == StFetch) || (state_q == StIssue) || (state_q == StGap);

   // Program loads are only accepted while no program is running.
   assign mem_we = prog_we && ena && ((state_q == StIdle) || (state_q == StDone));

   prog_mem_16x12 u_prog_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (prog_waddr),
      .wdata (prog_wdata),
      .raddr (pc_q),
      .rdata (mem_rdata)
   );

   // Next-state logic for the sequencer FSM, program counter and hold counter.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      hold_d  = hold_q;
      instr_d = instr_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d = StFetch;
               pc_d    = '0;
            end
         end
         StFetch: begin
            instr_d = instr_t'(mem_rdata);
            hold_d  = '0;
            state_d = (instr_d.opcode == HALT_OP) ? StDone : StIssue;
         end
         StIssue: begin
            if (hold_q == HoldLast) begin
               hold_d  = '0;
               state_d = StGap;
            end else begin
               hold_d = hold_q + 3'd1;
            end
         end
         StGap: begin
            // No wrap: running off the end of memory terminates normally.
            if (pc_q == 4'hF) begin
               state_d = StDone;
            end else begin
               pc_d    = pc_q + 4'd1;
               state_d = StFetch;
            end
         end
         default: state_d = StIdle;
      endcase
      // Abort overrides everything; pc keeps the interrupted index.
      if (abort && running) begin
         state_d = StIdle;
         pc_d    = pc_q;
         hold_d  = '0;
      end
   end

   // Output values for the coming cycle, derived from the next state so the
   // registered bus lines up with the state it belongs to.
   always_comb begin
      cpu_opcode_d = HALT_OP;
      cpu_addr_d   = '0;
      cpu_data_d   = '0;
      cpu_we_d     = 1'b0;
      if (state_d == StIssue) begin
         cpu_opcode_d = instr_d.opcode;
         cpu_addr_d   = instr_d.addr;
         cpu_data_d   = instr_d.data;
         cpu_we_d     = is_store(instr_d.opcode);
      end
      busy_d = (state_d == StFetch) || (state_d == StIssue) || (state_d == StGap);
      done_d = (state_d == StDone);
   end

   // State and output registers; ena low freezes all of them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         pc_q         <= '0;
         hold_q       <= '0;
         instr_q      <= '0;
         cpu_opcode_q <= HALT_OP;
         cpu_addr_q   <= '0;
         cpu_data_q   <= '0;
         cpu_we_q     <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else if (ena) begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         hold_q       <= hold_d;
         instr_q      <= instr_d;
         cpu_opcode_q <= cpu_opcode_d;
         cpu_addr_q   <= cpu_addr_d;
         cpu_data_q   <= cpu_data_d;
         cpu_we_q     <= cpu_we_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign cpu_opcode = cpu_opcode_q;
   assign cpu_addr   = cpu_addr_q;
   assign cpu_data   = cpu_data_q;
   assign cpu_we     = cpu_we_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pc         = pc_q;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Self-checking bench for instr_fetch_sequencer. A reference model expands the
// program image into the expected per-cycle bus trace and the DUT is compared
// against it cycle by cycle.
module tb_instr_fetch_sequencer;

   localparam int unsigned HOLD = 3;
   localparam logic [3:0]  HALT = 4'hF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        ena = 1'b1;
   logic        prog_we = 1'b0;
   logic [3:0]  prog_waddr = '0;
   logic [11:0] prog_wdata = '0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [3:0]  cpu_opcode, cpu_addr, cpu_data, pc;
   logic        cpu_we, busy, done;
   logic [18:0] obs;

   int checks = 0;
   int failures = 0;

   logic [11:0] mem_m [16];
   logic [18:0] exp_q [$];

   instr_fetch_sequencer #(
      .HOLD_CYCLES (HOLD),
      .HALT_OP     (HALT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .prog_we    (prog_we),
      .prog_waddr (prog_waddr),
      .prog_wdata (prog_wdata),
      .start      (start),
      .abort      (abort),
      .cpu_opcode (cpu_opcode),
      .cpu_addr   (cpu_addr),
      .cpu_data   (cpu_data),
      .cpu_we     (cpu_we),
      .busy       (busy),
      .done       (done),
      .pc         (pc)
   );

   always #5 clk = ~clk;

   assign obs = {cpu_opcode, cpu_addr, cpu_data, cpu_we, busy, done, pc};

   function automatic logic [18:0] vec(logic [3:0] op, logic [3:0] a, logic [3:0] d,
                                       logic we, logic bsy, logic dn, logic [3:0] p);
      return {op, a, d, we, bsy, dn, p};
   endfunction

   task automatic check(input string tag, input logic [18:0] o, input logic [18:0] e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [11:0] rand_word();
      logic [11:0] w;
      w = 12'($urandom);
      w[11:8] = 4'($urandom_range(0, 14));
      return w;
   endfunction

   task automatic write_word(input logic [3:0] a, input logic [11:0] w);
      prog_we = 1'b1;
      prog_waddr = a;
      prog_wdata = w;
      step();
      prog_we = 1'b0;
      mem_m[a] = w;
   endtask

   task automatic fill_random();
      for (int k = 0; k < 16; k++) write_word(4'(k), rand_word());
   endtask

   // Expected trace, one entry per cycle following the edge that samples start:
   // fetch, HOLD issue cycles, gap per instruction; a HALT fetch or the gap of
   // entry 15 is followed by the done state.
   function automatic void build_trace();
      bit         halted;
      logic [3:0] op;
      halted = 1'b0;
      exp_q.delete();
      for (int p = 0; p < 16 && !halted; p++) begin
         op = mem_m[p][11:8];
         exp_q.push_back(vec(HALT, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 4'(p)));
         if (op == HALT) begin
            exp_q.push_back(vec(HALT, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 4'(p)));
            halted = 1'b1;
         end else begin
            repeat (HOLD) exp_q.push_back(vec(op, mem_m[p][7:4], mem_m[p][3:0], op == 4'b0010,
                                              1'b1, 1'b0, 4'(p)));
            exp_q.push_back(vec(HALT, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 4'(p)));
            if (p == 15) exp_q.push_back(vec(HALT, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 4'hF));
         end
      end
   endfunction

   // Start a program and follow it; optional events at given trace indices.
   task automatic run(input string name, input int abort_at, input int meddle_at,
                      input int freeze_at, input int reset_at, input bit wr_start,
                      input logic [11:0] ws_word);
      int last;
      if (wr_start) begin
         prog_we = 1'b1;
         prog_waddr = 4'h0;
         prog_wdata = ws_word;
         mem_m[0] = ws_word;
      end
      build_trace();
      last = exp_q.size() - 1;
      start = 1'b1;
      step();
      start = 1'b0;
      prog_we = 1'b0;
      for (int i = 0; i <= last; i++) begin
         if (i > 0) begin
            step();
            start = 1'b0;
            prog_we = 1'b0;
         end
         check($sformatf("%s[%0d]", name, i), obs, exp_q[i]);
         if (i == abort_at) begin
            abort = 1'b1;
            step();
            abort = 1'b0;
            check({name, "_abort"}, obs, vec(HALT, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, exp_q[i][3:0]));
            return;
         end
         if (i == reset_at) begin
            #2 rst_n = 1'b0;
            #1 check({name, "_rst_async"}, obs, vec(HALT, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0));
            step();
            check({name, "_rst_held"}, obs, vec(HALT, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0));
            rst_n = 1'b1;
            return;
         end
         if (i == freeze_at) begin
            ena = 1'b0;
            repeat (3) begin
               step();
               check({name, "_freeze"}, obs, exp_q[i]);
            end
            ena = 1'b1;
         end
         if (i == meddle_at) begin
            prog_we = 1'b1;
            prog_waddr = 4'h0;
            prog_wdata = ~mem_m[0];
            start = 1'b1;
         end
      end
      step();
      check({name, "_done_hold"}, obs, exp_q[last]);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1 check("reset_async", obs, vec(HALT, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0));
      step();
      check("reset_held", obs, vec(HALT, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0));
      rst_n = 1'b1;
      step();
      check("idle_after_reset", obs, vec(HALT, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0));

      // LOAD / ADD / HALT program.
      fill_random();
      write_word(4'd0, 12'h330);
      write_word(4'd1, 12'h005);
      write_word(4'd2, 12'hF00);
      run("load_add_halt", -1, -1, -1, -1, 1'b0, 12'h0);

      // STORE drives cpu_we only while issued.
      write_word(4'd0, 12'h270);
      write_word(4'd1, 12'hF00);
      run("store", -1, -1, -1, -1, 1'b0, 12'h0);

      // Sixteen non-HALT entries: runs through pc 15 then done, no wrap.
      fill_random();
      run("full16", -1, -1, -1, -1, 1'b0, 12'h0);

      // Abort in the second issue cycle of entry 4.
      run("abort4", int'(4 * (HOLD + 2) + 2), -1, -1, -1, 1'b0, 12'h0);

      // From idle: write of entry 0 together with start is seen by the fetch.
      run("wr_with_start", -1, -1, -1, -1, 1'b1, rand_word());

      // Writes and start during a run are ignored; rerun confirms memory.
      write_word(4'd3, {HALT, 8'($urandom)});
      run("meddle", -1, 2, -1, -1, 1'b0, 12'h0);
      run("rerun", -1, -1, -1, -1, 1'b0, 12'h0);

      // ena low freezes everything mid-run.
      fill_random();
      run("freeze", -1, -1, 5, -1, 1'b0, 12'h0);

      // Random programs with a random HALT position (or none).
      for (int r = 0; r < 4; r++) begin
         int hp;
         fill_random();
         hp = $urandom_range(0, 16);
         if (hp < 16) write_word(4'(hp), {HALT, 8'($urandom)});
         run($sformatf("rand%0d", r), -1, -1, -1, -1, 1'b0, 12'h0);
      end

      // Reset asserted while a STORE is on the bus, then a clean rerun.
      write_word(4'd0, 12'h270);
      run("reset_mid_issue", -1, -1, -1, 2, 1'b0, 12'h0);
      step();
      run("after_reset", -1, -1, -1, -1, 1'b0, 12'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
